// File: rtl/arb_pkg.sv
// Shared arbiter definitions: FSM state encodings and counter sizing helper.
package arb_pkg;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Hold counter width for a given hold limit.
  function automatic int hold_w(input int max);
    return $clog2(max) + 1;
  endfunction

endpackage

// File: rtl/hold_counter.sv
// Saturating grant-hold counter. It clears on clr, otherwise counts inc
// cycles and sticks at MAX-1.
module hold_counter #(
  parameter  int MAX = 8,
  localparam int W   = $clog2(MAX) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] TOP = W'(MAX - 1);

  // Clear has priority. Counting stops at TOP, so an uncontested owner
  // never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   count <= '0;
    else if (clr)                 count <= '0;
    else if (inc && count != TOP) count <= count + W'(1);
  end

endmodule

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter with done/release handoff and
// a hold timeout that preempts only when the other requester is waiting.
module rr_arbiter_2 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       done,
  output logic       sel,
  output logic       gnt_valid
);
  import arb_pkg::*;

  localparam int           HW       = hold_w(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);

  logic [0:0]    state, nxt_state;
  logic          nxt_sel;
  logic          last;
  logic          clr, inc;
  logic [HW-1:0] hold_cnt;
  logic          other, timeout, rel;

  hold_counter #(.MAX(MAX_HOLD)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (inc),
    .count (hold_cnt)
  );

  assign other   = req[~sel];
  assign timeout = (hold_cnt == HOLD_TOP) && other;
  // done and timeout together form one release, so sel toggles only once.
  assign rel     = done || !req[sel] || timeout;

  // Next-state / next-select logic. A release hands off directly when the
  // other side is waiting, so no bubble cycle is inserted.
  always_comb begin
    nxt_state = state;
    nxt_sel   = sel;
    clr       = 1'b0;
    inc       = 1'b0;
    case (state)
      IDLE: begin
        clr = 1'b1;
        if (req != 2'b00) begin
          nxt_state = GRANT;
          nxt_sel   = (req == 2'b11) ? ~last : req[1];
        end
      end
      GRANT: begin
        if (rel) begin
          clr = 1'b1;
          if (other) nxt_sel   = ~sel;
          else       nxt_state = IDLE;
        end else begin
          inc = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // State and output registers. Reset sets last=1 so requester 0 wins the
  // first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= 1'b0;
      gnt_valid <= 1'b0;
      last      <= 1'b1;
    end else begin
      state     <= nxt_state;
      sel       <= nxt_sel;
      gnt_valid <= (nxt_state == GRANT);
      if (nxt_state == GRANT) last <= nxt_sel;
    end
  end

endmodule

// File: doc/rr_arbiter_2.md
RR_ARBITER_2 -- requirements
Module: rr_arbiter_2

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive grant cycles while the other requester waits; legal range 1..255.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  2  request per requester; bit i = requester i.
REQ-005 Port: done  input  1  single-cycle release pulse from the current grant owner.
REQ-006 Port: sel  output  1  index of granted requester; drives the downstream 1x2 decoder select.
REQ-007 Port: gnt_valid  output  1  high while sel denotes an active grant.

Function
REQ-008 States SHALL be IDLE (no grant, gnt_valid=0) and GRANT (gnt_valid=1).
REQ-009 sel and gnt_valid SHALL be registered outputs with no combinational path from inputs.
REQ-010 IDLE with req=00: stay IDLE; sel holds its last value.
REQ-011 IDLE with exactly one req bit set: go GRANT with sel = that index at the next edge (1-cycle latency).
REQ-012 IDLE with req=11: grant index ~last, where last is the most recently granted index (round-robin tie-break).
REQ-013 In GRANT, release SHALL occur at an edge when done=1, or req[sel]=0, or (hold_cnt == MAX_HOLD-1 and req[~sel]=1).
REQ-014 Release with req[~sel]=1: switch sel to ~sel, stay in GRANT, clear hold_cnt; no bubble cycle.
REQ-015 Release with req[~sel]=0: go IDLE, gnt_valid=0 at the next edge; sel unchanged.
REQ-016 hold_cnt SHALL increment each GRANT cycle without release, clear on every grant start or switch, and saturate at MAX_HOLD-1 while req[~sel]=0.
REQ-017 Timeout SHALL never preempt when the other requester is idle; the owner keeps the grant indefinitely.
REQ-018 done asserted together with timeout SHALL be treated as a single release, per REQ-014/015.
REQ-019 done in IDLE SHALL be ignored.
REQ-020 last SHALL update to sel on every transition into or within GRANT.
REQ-021 hold_cnt width SHALL be clog2(MAX_HOLD)+1 bits; for MAX_HOLD=1, every GRANT cycle with the other requester waiting is a release.

Reset
REQ-022 rst_n=0 SHALL immediately and asynchronously force state=IDLE, sel=0, gnt_valid=0, hold_cnt=0, last=1, so requester 0 wins the first tie.
REQ-023 Reset asserted mid-grant SHALL drop gnt_valid without waiting for a clock edge.
REQ-024 After rst_n deasserts, the first grant SHALL occur at the first rising edge with req!=00.

Structure
REQ-025 State encodings (IDLE=1'b0, GRANT=1'b1) SHALL live in the shared package arb_pkg for reuse by later N-way arbiters.
REQ-026 The saturating hold counter SHALL be the sub-module hold_counter (inputs clr, inc; output count; parameter MAX).
REQ-027 The top level SHALL contain only the FSM, the last register and the output registers.

Verification
REQ-028 Reset, then req=11 at edge 1 -> sel=0, gnt_valid=1 after edge 1; done pulse -> sel=1 after the next edge, gnt_valid held at 1.
REQ-029 req=10 only, done pulse at cycle 5 -> sel=1 granted at edge 1; IDLE (gnt_valid=0) after the edge on which done=1.
REQ-030 MAX_HOLD=4, requester 0 granted, req[1] raised at cycle 2 -> sel switches to 1 exactly 4 grant cycles after the grant start.
REQ-031 MAX_HOLD=4, req=01 held 20 cycles -> sel=0, gnt_valid=1 throughout; no preemption.
REQ-032 rst_n pulled low mid-cycle during GRANT with sel=1 -> gnt_valid=0 and sel=0 before the next clock edge.
REQ-033 done and timeout in the same cycle with req=11 -> exactly one switch; sel toggles once.
